lifo_stack: RTL and testbench

LIFO_STACK -- requirements
Module: lifo_stack

---
 rtl/lifo_stack.sv | 122 ++++++++++++
 tb/tb_lifo_stack.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/lifo_stack.sv
// LIFO stack with push/pop/tos/dup commands, registered read port and
// sticky overflow/underflow flags. Memory is not reset; control state is.
module lifo_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             push,
    input  logic             pop,
    input  logic             tos,
    input  logic             dup,
    input  logic             err_clr,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             ovf,
    output logic             unf
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    nxt_idx;
    logic [WIDTH-1:0] top_data;

    logic [CW-1:0]    cnt_nxt;
    logic             we;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;
    logic             rd_en;
    logic             ovf_set;
    logic             unf_set;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign top_idx  = AW'(count - CW'(1));
    assign nxt_idx  = AW'(count);
    assign top_data = mem[top_idx];

    // Command decode: pop dominates, then push, then dup; tos only reads.
    always_comb begin
        cnt_nxt = count;
        we      = 1'b0;
        waddr   = nxt_idx;
        wdata   = din;
        rd_en   = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (pop) begin
            if (!empty) begin
                rd_en = 1'b1;
                if (push) begin
                    we    = 1'b1;
                    waddr = top_idx;
                end else begin
                    cnt_nxt = count - CW'(1);
                end
            end else begin
                unf_set = 1'b1;
                if (push) begin
                    we      = 1'b1;
                    cnt_nxt = count + CW'(1);
                end
            end
        end else if (push) begin
            rd_en = tos && !empty;
            if (!full) begin
                we      = 1'b1;
                cnt_nxt = count + CW'(1);
            end else begin
                ovf_set = 1'b1;
            end
        end else begin
            rd_en = tos && !empty;
            if (dup) begin
                if (empty) begin
                    unf_set = 1'b1;
                end else if (full) begin
                    ovf_set = 1'b1;
                end else begin
                    we      = 1'b1;
                    wdata   = top_data;
                    cnt_nxt = count + CW'(1);
                end
            end
        end
    end

    // Control and read-data registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            ovf        <= 1'b0;
            unf        <= 1'b0;
        end else begin
            count      <= cnt_nxt;
            dout_valid <= rd_en;
            if (rd_en) begin
                dout <= top_data;
            end
            ovf <= ovf_set | (ovf & ~err_clr);
            unf <= unf_set | (unf & ~err_clr);
        end
    end

    // Storage: no reset, writes suppressed while rst is held
    always_ff @(posedge clk) begin
        if (we && !rst) begin
            mem[waddr] <= wdata;
        end
    end

endmodule

// File: tb/tb_lifo_stack.sv
// Bench for lifo_stack (DEPTH=4): directed scenarios followed by random
// command mixes, compared against a queue-based reference model.
module tb_lifo_stack;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] din = '0;
    logic             push = 1'b0, pop = 1'b0, tos = 1'b0, dup = 1'b0, err_clr = 1'b0;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic [CW-1:0]    count;
    logic             empty, full, ovf, unf;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] stk [$];
    logic [WIDTH-1:0] m_dout  = '0;
    logic             m_valid = 1'b0;
    logic             m_ovf   = 1'b0;
    logic             m_unf   = 1'b0;

    lifo_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .din(din), .push(push), .pop(pop), .tos(tos),
        .dup(dup), .err_clr(err_clr), .dout(dout), .dout_valid(dout_valid),
        .count(count), .empty(empty), .full(full), .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".count"}, 32'(count), 32'(stk.size()));
        chk({tag, ".empty"}, 32'(empty), 32'(stk.size() == 0));
        chk({tag, ".full"},  32'(full),  32'(stk.size() == DEPTH));
        chk({tag, ".valid"}, 32'(dout_valid), 32'(m_valid));
        chk({tag, ".dout"},  32'(dout), 32'(m_dout));
        chk({tag, ".ovf"},   32'(ovf), 32'(m_ovf));
        chk({tag, ".unf"},   32'(unf), 32'(m_unf));
    endtask

    task automatic model_reset();
        stk.delete();
        m_dout  = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    // Reference behaviour stated directly in stack terms
    task automatic model_step(input logic p, input logic q, input logic t, input logic d,
                              input logic ec, input logic [WIDTH-1:0] v);
        logic oe, ue;
        oe = 1'b0;
        ue = 1'b0;
        m_valid = 1'b0;
        if (q) begin
            if (stk.size() > 0) begin
                m_dout  = stk.pop_back();
                m_valid = 1'b1;
            end else begin
                ue = 1'b1;
            end
            if (p) stk.push_back(v);
        end else begin
            if (t && stk.size() > 0) begin
                m_dout  = stk[$];
                m_valid = 1'b1;
            end
            if (p) begin
                if (stk.size() < DEPTH) stk.push_back(v);
                else oe = 1'b1;
            end else if (d) begin
                if (stk.size() == 0) ue = 1'b1;
                else if (stk.size() == DEPTH) oe = 1'b1;
                else stk.push_back(stk[$]);
            end
        end
        m_ovf = oe | (m_ovf & ~ec);
        m_unf = ue | (m_unf & ~ec);
    endtask

    task automatic cyc(input string tag, input logic p, input logic q, input logic t,
                       input logic d, input logic ec, input logic [WIDTH-1:0] v);
        push = p; pop = q; tos = t; dup = d; err_clr = ec; din = v;
        @(posedge clk);
        model_step(p, q, t, d, ec, v);
        #1;
        check_all(tag);
        push = 0; pop = 0; tos = 0; dup = 0; err_clr = 0;
    endtask

    initial begin
        model_reset();
        #1;
        check_all("reset");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Basic LIFO order
        cyc("r39.push", 1, 0, 0, 0, 0, 8'h11);
        cyc("r39.push", 1, 0, 0, 0, 0, 8'h22);
        cyc("r39.push", 1, 0, 0, 0, 0, 8'h33);
        cyc("r39.pop1", 0, 1, 0, 0, 0, 8'h00);
        chk("r39.d1", 32'(dout), 32'h33);
        cyc("r39.pop2", 0, 1, 0, 0, 0, 8'h00);
        chk("r39.d2", 32'(dout), 32'h22);
        cyc("r39.pop3", 0, 1, 0, 0, 0, 8'h00);
        chk("r39.d3", 32'(dout), 32'h11);
        chk("r39.empty", 32'(empty), 32'h1);
        cyc("r39.idle", 0, 0, 0, 0, 0, 8'h00);

        // Overflow at DEPTH
        for (int i = 1; i <= 5; i++) cyc("r40.push", 1, 0, 0, 0, 0, 8'(i));
        chk("r40.count", 32'(count), 32'd4);
        chk("r40.ovf", 32'(ovf), 32'h1);
        cyc("r40.pop", 0, 1, 0, 0, 0, 8'h00);
        chk("r40.dout", 32'(dout), 32'h04);
        for (int i = 0; i < 3; i++) cyc("r40.drain", 0, 1, 0, 0, 0, 8'h00);
        cyc("r40.clr", 0, 0, 0, 0, 1, 8'h00);

        // Underflow and err_clr priority
        cyc("r41.pop", 0, 1, 0, 0, 0, 8'h00);
        chk("r41.unf", 32'(unf), 32'h1);
        cyc("r41.clr", 0, 0, 0, 0, 1, 8'h00);
        chk("r41.unf0", 32'(unf), 32'h0);
        cyc("r41.popclr", 0, 1, 0, 0, 1, 8'h00);
        chk("r41.unf1", 32'(unf), 32'h1);
        cyc("r41.clr2", 0, 0, 0, 0, 1, 8'h00);

        // Replace and tos
        cyc("r42.push", 1, 0, 0, 0, 0, 8'hA0);
        cyc("r42.push", 1, 0, 0, 0, 0, 8'hB0);
        cyc("r42.repl", 1, 1, 0, 0, 0, 8'hC0);
        chk("r42.dout", 32'(dout), 32'hB0);
        cyc("r42.tos", 0, 0, 1, 0, 0, 8'h00);
        chk("r42.tosd", 32'(dout), 32'hC0);
        chk("r42.cnt", 32'(count), 32'd2);
        cyc("r42.drain", 0, 1, 0, 0, 0, 8'h00);
        cyc("r42.drain", 0, 1, 0, 0, 0, 8'h00);

        // Dup
        cyc("r43.push", 1, 0, 0, 0, 0, 8'h5A);
        cyc("r43.dup", 0, 0, 0, 1, 0, 8'h00);
        chk("r43.cnt", 32'(count), 32'd2);
        cyc("r43.pop1", 0, 1, 0, 0, 0, 8'h00);
        chk("r43.d1", 32'(dout), 32'h5A);
        cyc("r43.pop2", 0, 1, 0, 0, 0, 8'h00);
        chk("r43.d2", 32'(dout), 32'h5A);
        cyc("r43.dupe", 0, 0, 0, 1, 0, 8'h00);
        chk("r43.unf", 32'(unf), 32'h1);
        cyc("r43.clr", 0, 0, 0, 0, 1, 8'h00);

        // Random command mixes
        for (int i = 0; i < 600; i++) begin
            cyc("rand", 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0),
                1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0),
                1'($urandom_range(0, 7) == 0), 8'($urandom));
        end

        // Asynchronous reset mid-cycle
        cyc("r44.clr", 0, 0, 0, 0, 1, 8'h00);
        cyc("r44.pre", 1, 0, 0, 0, 0, 8'h99);
        cyc("r44.pre", 0, 1, 0, 0, 0, 8'h00);
        while (count != 0) cyc("r44.drain", 0, 1, 0, 0, 0, 8'h00);
        cyc("r44.unf", 0, 1, 0, 0, 0, 8'h00);
        cyc("r44.push", 1, 0, 0, 0, 0, 8'h77);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("r44.async");
        @(negedge clk);
        rst = 1'b0;
        cyc("r44.push1", 1, 0, 0, 0, 0, 8'h01);
        cyc("r44.pop", 0, 1, 0, 0, 0, 8'h00);
        chk("r44.dout", 32'(dout), 32'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
